// File: rtl/multislope_dac.sv
// multislope_dac: turns each code into a dump/settle, coarse +/-ref and weighted fine switch frame
module multislope_dac #(
    parameter int CODE_W     = 8,
    parameter int FINE_BITS  = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              sw_dump,
    output logic              sw_pos,
    output logic              sw_neg,
    output logic              sw_fine,
    output logic              busy,
    output logic              frame_done
);
    localparam int CB    = CODE_W - FINE_BITS;
    localparam int NC    = 1 << CB;
    localparam int NF    = 1 << FINE_BITS;
    localparam int MW    = CB > FINE_BITS ? CB : FINE_BITS;
    localparam int CNT_W = (MW > $clog2(SETTLE_CYC) ? MW : $clog2(SETTLE_CYC)) + 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] COARSE = 3'd2;
    localparam logic [2:0] FINE   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CODE_W-1:0] act, act_n, pend;
    logic              pend_full, pend_n, accept, drain;

    assign accept = code_valid && code_ready;
    assign drain  = pend_full && (state == IDLE || state == DONE);
    assign pend_n = accept || (pend_full && !drain);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        act_n   = act;
        if (drain) begin
            state_n = SETTLE;
            cnt_n   = '0;
            act_n   = pend;
        end else if (state == DONE) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            cnt_n   = '0;
        end else if (state == SETTLE && cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state_n = COARSE;
            cnt_n   = '0;
        end else if (state == COARSE && cnt == CNT_W'(NC - 1)) begin
            state_n = FINE;
            cnt_n   = '0;
        end else if (state == FINE && cnt == CNT_W'(NF - 1)) begin
            state_n = DONE;
            cnt_n   = '0;
        end
    end

    // Switch drive is decoded from the next state so the registered outputs line up with it
    logic coarse_n, pos_n, fine_n;
    assign coarse_n = state_n == COARSE;
    assign pos_n    = cnt_n < CNT_W'(act_n[CODE_W-1:FINE_BITS]);
    assign fine_n   = state_n == FINE && cnt_n < CNT_W'(act_n[FINE_BITS-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            act        <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            code_ready <= 1'b0;
            sw_dump    <= 1'b1;
            sw_pos     <= 1'b0;
            sw_neg     <= 1'b0;
            sw_fine    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            act        <= act_n;
            pend       <= accept ? code_in : pend;
            pend_full  <= pend_n;
            code_ready <= !pend_n;
            sw_dump    <= state_n == IDLE || state_n == SETTLE || state_n == DONE;
            sw_pos     <= coarse_n && pos_n;
            sw_neg     <= coarse_n && !pos_n;
            sw_fine    <= fine_n;
            busy       <= state_n != IDLE;
            frame_done <= state_n == DONE;
        end
    end
endmodule
